// File: rtl/object_mask_collector.sv
// object_mask_collector: packs a binary object mask frame into a word buffer, tracks count/bounding box, hands off via ready/ack
module object_mask_collector #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              frame_sync,
  input  logic              object_image,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic [14:0]       obj_count,
  output logic              obj_empty,
  output logic [7:0]        min_x,
  output logic [7:0]        max_x,
  output logic [6:0]        min_y,
  output logic [6:0]        max_y,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [7:0]        dropped_frames
);
  localparam int WPL    = IMG_W / WORD_W;
  localparam int NWORDS = IMG_W * IMG_H / WORD_W;
  localparam int BW     = $clog2(WORD_W);
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;
  state_t r_state, w_next;
  logic [7:0] r_x, w_x, r_min_x, r_max_x, w_b_min_x, w_b_max_x, w_n_min_x, w_n_max_x;
  logic [6:0] r_y, w_y, r_min_y, r_max_y, w_b_min_y, w_b_max_y, w_n_min_y, w_n_max_y;
  logic [14:0] r_count, w_b_count, w_n_count;
  logic r_empty, w_b_empty, w_n_empty;
  logic [7:0] r_dropped;
  logic [WORD_W-1:0] r_word, w_wdata, r_rd_data;
  logic [WORD_W-1:0] r_mem [0:NWORDS-1];
  logic w_sof, w_last, w_restart, w_take, w_wr, w_eol;
  logic [ADDR_W-1:0] w_addr;
  assign w_sof     = pix_valid & frame_sync;
  assign w_last    = (r_x == 8'(IMG_W - 1)) && (r_y == 7'(IMG_H - 1));
  // a sync pixel starts a frame from IDLE, aborts a partial frame, or pairs with an ack in HOLD
  assign w_restart = w_sof & ((r_state == IDLE) | ((r_state == CAPTURE) & ~w_last) | ((r_state == HOLD) & frame_ack));
  assign w_take    = pix_valid & ((r_state == CAPTURE) | w_restart);
  assign w_x       = w_restart ? '0 : r_x;
  assign w_y       = w_restart ? '0 : r_y;
  assign w_eol     = w_x == 8'(IMG_W - 1);
  assign w_wr      = w_take & (&w_x[BW-1:0]);
  assign w_addr    = ADDR_W'(w_y) * ADDR_W'(WPL) + ADDR_W'(w_x >> BW);
  assign frame_ready    = r_state == HOLD;
  assign obj_count      = r_count;
  assign obj_empty      = r_empty;
  assign min_x          = r_min_x;
  assign max_x          = r_max_x;
  assign min_y          = r_min_y;
  assign max_y          = r_max_y;
  assign dropped_frames = r_dropped;
  assign rd_data        = r_rd_data;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state: the last pixel always completes the frame, even if it carries a sync
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE    ? (w_sof ? CAPTURE : IDLE) :
             r_state == CAPTURE ? ((pix_valid & w_last) ? HOLD : CAPTURE) :
             (frame_ack ? (w_sof ? CAPTURE : IDLE) : HOLD);
  end
  // merge the current pixel into the word being assembled (LSB = leftmost)
  always_comb begin
    w_wdata = r_word;
    w_wdata[w_x[BW-1:0]] = object_image;
  end
  // statistics update: start from cleared values on a restart, first object pixel seeds the box
  always_comb begin
    w_b_count = w_restart ? '0 : r_count;
    w_b_empty = w_restart | r_empty;
    w_b_min_x = w_restart ? '0 : r_min_x;
    w_b_max_x = w_restart ? '0 : r_max_x;
    w_b_min_y = w_restart ? '0 : r_min_y;
    w_b_max_y = w_restart ? '0 : r_max_y;
    w_n_count = w_b_count + 15'(object_image);
    w_n_empty = w_b_empty & ~object_image;
    w_n_min_x = (object_image & (w_b_empty | (w_x < w_b_min_x))) ? w_x : w_b_min_x;
    w_n_max_x = (object_image & (w_b_empty | (w_x > w_b_max_x))) ? w_x : w_b_max_x;
    w_n_min_y = (object_image & (w_b_empty | (w_y < w_b_min_y))) ? w_y : w_b_min_y;
    w_n_max_y = (object_image & (w_b_empty | (w_y > w_b_max_y))) ? w_y : w_b_max_y;
  end
  // pixel position, packing register and statistics advance only on accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
      r_word <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_min_x <= '0;
      r_max_x <= '0;
      r_min_y <= '0;
      r_max_y <= '0;
    end else if (w_take) begin
      r_x <= w_eol ? '0 : w_x + 8'd1;
      r_y <= w_eol ? w_y + 7'd1 : w_y;
      r_word <= w_wdata;
      r_count <= w_n_count;
      r_empty <= w_n_empty;
      r_min_x <= w_n_min_x;
      r_max_x <= w_n_max_x;
      r_min_y <= w_n_min_y;
      r_max_y <= w_n_max_y;
    end
  end
  // frames that start while the previous one is still held are counted, saturating
  always_ff @(posedge clk) begin
    if (rst)
      r_dropped <= '0;
    else if ((r_state == HOLD) & w_sof & ~frame_ack & (r_dropped != 8'hFF))
      r_dropped <= r_dropped + 8'd1;
  end
  // buffer write when a word is complete
  always_ff @(posedge clk)
    if (!rst && w_wr) r_mem[w_addr] <= w_wdata;
  // registered read port, out-of-range addresses read as zero
  always_ff @(posedge clk)
    r_rd_data <= (rst || rd_addr >= ADDR_W'(NWORDS)) ? '0 : r_mem[rd_addr];
endmodule

// File: tb/tb_object_mask_collector.sv
// tb_object_mask_collector: randomized frames against a frame-level reference model with a scoreboard monitor
module tb_object_mask_collector;
  localparam int W = 48, H = 40, WW = 16, AW = 11, NP = W * H, NW = NP / WW;
  logic clk = 0, rst = 1, pix_valid = 0, frame_sync = 0, object_image = 0, frame_ack = 0;
  logic [AW-1:0] rd_addr = '0;
  logic frame_ready, obj_empty;
  logic [14:0] obj_count;
  logic [7:0] min_x, max_x, dropped_frames;
  logic [6:0] min_y, max_y;
  logic [WW-1:0] rd_data;
  object_mask_collector #(.IMG_W(W), .IMG_H(H), .WORD_W(WW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_sync(frame_sync), .object_image(object_image),
    .frame_ready(frame_ready), .frame_ack(frame_ack), .obj_count(obj_count), .obj_empty(obj_empty),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y), .rd_addr(rd_addr), .rd_data(rd_data),
    .dropped_frames(dropped_frames)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct packed {
    logic [14:0] cnt;
    logic        empty;
    logic [7:0]  minx, maxx;
    logic [6:0]  miny, maxy;
    int          rise;
  } exp_t;
  exp_t q[$];
  exp_t held;
  logic [WW-1:0] exp_mem [NW];
  bit m_img [NP];
  bit m_held = 0;
  int m_dropped = 0, checks_done = 0, nasrt = 0, nfail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nasrt++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step(input bit v, input bit s, input bit b, input bit ack, input bit r);
    @(posedge clk);
    #1;
    pix_valid = v;
    frame_sync = s;
    object_image = b;
    frame_ack = ack;
    rst = r;
  endtask
  function automatic bit pat(input int kind, input int x, input int y);
    case (kind)
      0: return 0;
      1: return x == 37 && y == 30;
      2: return x >= 20 && x <= 39 && y >= 10 && y <= 29;
      3: return x == 0 && y == 0;
      4: return $urandom_range(0, 99) < 3;
      default: return 1'($urandom);
    endcase
  endfunction
  task automatic send(input int kind, input int stall, input int stop_at, input bit ack_sync);
    bit accept = 0, b, e;
    int lc = 0, cnt, mnx, mxx, mny, mxy;
    exp_t ex;
    for (int p = 0; p < NP; p++) begin
      if (p == stop_at) return;
      while ($urandom_range(0, 99) < stall) step(0, 1'($urandom), 1'($urandom), 0, 0);
      b = pat(kind, p % W, p / W);
      if (p == 0) begin
        if (m_held && !ack_sync && m_dropped < 255) m_dropped++;
        if (ack_sync) m_held = 0;
        accept = !m_held;
      end
      if (accept) m_img[p] = b;
      step(1, p == 0, b, p == 0 && ack_sync, 0);
      lc = cyc;
    end
    step(0, 0, 0, 0, 0);
    if (!accept) return;
    cnt = 0; e = 1; mnx = 0; mxx = 0; mny = 0; mxy = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (m_img[y * W + x]) begin
          cnt++;
          if (e) begin mnx = x; mxx = x; mny = y; mxy = y; e = 0; end
          else begin
            if (x < mnx) mnx = x;
            if (x > mxx) mxx = x;
            if (y < mny) mny = y;
            if (y > mxy) mxy = y;
          end
        end
    for (int a = 0; a < NW; a++)
      for (int i = 0; i < WW; i++) exp_mem[a][i] = m_img[a * WW + i];
    ex.cnt = 15'(cnt); ex.empty = e; ex.minx = 8'(mnx); ex.maxx = 8'(mxx);
    ex.miny = 7'(mny); ex.maxy = 7'(mxy); ex.rise = lc + 1;
    q.push_back(ex);
    m_held = 1;
  endtask
  task automatic wait_check(input int prev);
    int t = 0;
    while (checks_done == prev && t < 2000) begin
      step(0, 0, 0, 0, 0);
      t++;
    end
    chk("frame_checked", 32'(checks_done > prev), 1);
  endtask
  task automatic do_ack();
    step(0, 0, 0, 1, 0);
    m_held = 0;
    step(0, 0, 0, 0, 0);
  endtask
  task automatic full(input int kind, input int stall, input bit ack);
    int prev = checks_done;
    send(kind, stall, -1, 0);
    wait_check(prev);
    if (ack) do_ack();
  endtask
  // monitor: reset values, frame hand-off stats, latency, buffer contents, held outputs at ack
  initial begin
    bit pr = 0, prst = 0;
    int mism, a;
    logic [WW-1:0] ew;
    forever begin
      @(negedge clk);
      if (prst) begin
        chk("reset_ready", 32'(frame_ready), 0);
        chk("reset_count", 32'(obj_count), 0);
        chk("reset_empty", 32'(obj_empty), 1);
        chk("reset_box", {min_x, max_x, min_y, max_y, 2'b0}, 0);
        chk("reset_dropped", 32'(dropped_frames), 0);
        chk("reset_rd_data", 32'(rd_data), 0);
      end
      if (frame_ready && !pr) begin
        if (q.size() == 0) chk("spurious_ready", 1, 0);
        else begin
          held = q.pop_front();
          chk("ready_latency", cyc, held.rise);
          chk("obj_count", 32'(obj_count), 32'(held.cnt));
          chk("obj_empty", 32'(obj_empty), 32'(held.empty));
          chk("min_x", 32'(min_x), 32'(held.minx));
          chk("max_x", 32'(max_x), 32'(held.maxx));
          chk("min_y", 32'(min_y), 32'(held.miny));
          chk("max_y", 32'(max_y), 32'(held.maxy));
          chk("dropped_at_ready", 32'(dropped_frames), m_dropped);
          mism = 0;
          for (int k = 0; k < NW + 4; k++) begin
            a = k < NW ? k : k == NW ? NW : k == NW + 1 ? 2047 : $urandom_range(NW, 2047);
            rd_addr = AW'(a);
            @(negedge clk);
            ew = a < NW ? exp_mem[a] : '0;
            if (rd_data !== ew) begin
              mism++;
              if (mism == 1) chk($sformatf("mask_word[%0d]", a), 32'(rd_data), 32'(ew));
            end
          end
          chk("mask_mismatch_count", mism, 0);
          checks_done++;
        end
      end
      if (frame_ready && frame_ack) begin
        chk("held_count", 32'(obj_count), 32'(held.cnt));
        chk("held_box", {min_x, max_x, min_y, max_y, 2'b0}, {held.minx, held.maxx, held.miny, held.maxy, 2'b0});
        chk("held_dropped", 32'(dropped_frames), m_dropped);
      end
      pr = frame_ready;
      prst = rst;
    end
  end
  initial begin
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    full(0, 0, 1);
    full(1, 10, 1);
    full(2, 30, 1);
    send(5, 0, 1000, 0);
    full(3, 0, 1);
    full(5, 5, 0);
    repeat (3) send(5, 10, -1, 0);
    begin
      int prev = checks_done;
      send(4, 10, -1, 1);
      wait_check(prev);
      do_ack();
    end
    send(5, 0, 1000, 0);
    step(0, 0, 0, 0, 1);
    m_dropped = 0;
    step(0, 0, 0, 0, 0);
    full(4, 20, 1);
    full(5, 0, 1);
    repeat (10) step(0, 0, 0, 0, 0);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule

// File: doc/object_mask_collector.md
Name: object_mask_collector

Overview:
- Consumes the 1-bit per-pixel skin/object decision stream from the segmentation stage, one pixel per clock in raster order.
- Packs a 160x120 binary frame into an internal word-addressed buffer and accumulates object pixel count and bounding box.
- Hands the completed frame to the gesture feature extractor through a ready/ack handshake.
- Exposes a synchronous read port so the feature extractor can read the packed mask.

Parameters:
- IMG_W, 160, pixels per line; must be a multiple of WORD_W.
- IMG_H, 120, lines per frame.
- WORD_W, 16, mask bits packed per buffer word.
- ADDR_W, 11, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H/WORD_W (1200).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  object_image is valid this cycle.
- frame_sync  in  1  marks the first pixel (x=0,y=0) of a frame; only meaningful when pix_valid=1.
- object_image  in  1  mask bit: 1 = object pixel.
- frame_ready  out  1  completed frame and statistics are held and stable.
- frame_ack  in  1  consumer has finished with the frame.
- obj_count  out  15  number of 1 pixels in the frame.
- obj_empty  out  1  frame contains no object pixel.
- min_x, max_x  out  8 each  bounding box columns.
- min_y, max_y  out  7 each  bounding box rows.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  WORD_W  buffer word; valid 1 cycle after rd_addr.
- dropped_frames  out  8  saturating count of frames that arrived while the block was in HOLD.

Behaviour:
- Reset: state IDLE; frame_ready=0, obj_count=0, obj_empty=1, min_x=0, max_x=0, min_y=0, max_y=0, dropped_frames=0, rd_data=0. Buffer contents are undefined after reset.
- The FSM has three states: IDLE, CAPTURE, HOLD.
- IDLE:
  - Wait for pix_valid & frame_sync.
  - On that cycle, accept the pixel as (0,0), clear all statistics, and go to CAPTURE.
  - Other pixels are discarded.
- CAPTURE:
  - Each pix_valid cycle processes one pixel at (x,y). x wraps at IMG_W-1 and then y increments.
  - Cycles with pix_valid=0 are stalls. No state changes during a stall.
  - Object pixel handling:
    - obj_count increments when object_image=1.
    - On the first 1 of the frame, set min_x=max_x=x and min_y=max_y=y, and set obj_empty=0.
    - On later 1s, update each bound with the compare against the current pixel.
  - Packing:
    - Bit (x mod WORD_W) of a shift/accumulate register holds the pixel, LSB = leftmost pixel.
    - When x mod WORD_W = WORD_W-1, write the word to address y*(IMG_W/WORD_W) + x/WORD_W.
  - Frame end:
    - Pixel (IMG_W-1, IMG_H-1) completes the frame.
    - The next cycle enters HOLD with frame_ready=1 and final statistics visible.
    - Latency from last pixel to frame_ready is 1 clock.
  - frame_sync & pix_valid mid-frame (not at the last pixel) aborts the current frame. That pixel is taken as (0,0) of a new frame, statistics are cleared, and the FSM stays in CAPTURE.
- HOLD:
  - Outputs and buffer are frozen. Incoming pixels are ignored.
  - Each pix_valid & frame_sync increments dropped_frames, saturating at 255.
  - On frame_ack=1, drop frame_ready next cycle.
    - If frame_sync & pix_valid occur in the same cycle, go directly to CAPTURE with that pixel as (0,0). That frame is not counted as dropped.
    - Otherwise go to IDLE.
- frame_ack outside HOLD is ignored.
- Statistics outputs are only guaranteed stable while frame_ready=1.
- Read port:
  - rd_data is registered from buffer[rd_addr] every cycle, in any state.
  - Addresses >= 1200 return 0.
- Widths: obj_count max 19200, which fits in 15 bits; no overflow possible.
- Reset mid-operation returns the block to IDLE immediately on the next edge and discards the partial frame.

Test Plan:
- Full frame of all zeros, no stalls -> frame_ready rises 1 clk after pixel 19199; obj_count=0, obj_empty=1, box=0; every word reads 0x0000.
- Single object pixel at (37,90) -> obj_count=1, min_x=max_x=37, min_y=max_y=90; addr 90*10+2=902 reads 0x0020, all other words 0.
- Filled rectangle x=20..59, y=10..29, random pix_valid stalls (~30% low) -> obj_count=800, box (20,59,10,29); word at y=10, addr 101 reads 0xFFF0.
- frame_sync at pixel 5000 of a frame, then a clean frame with one pixel at (0,0) -> only the second frame reported: obj_count=1, box all 0, obj_empty=0.
- Hold frame_ack low and send 3 more frames -> outputs unchanged, dropped_frames=3. Then assert frame_ack together with frame_sync -> next frame captured, frame_ready re-asserts after it completes.
- Assert rst for 1 cycle mid-CAPTURE at pixel 10000 -> frame_ready=0 and all outputs at reset values next cycle; the following full frame is captured correctly.
